// File: rtl/press_count_pkg.sv
// Shared types and constants for the press counter.
// HEX_MODE_EN (macro): when defined, each digit counts 0..F instead of 0..9.
package press_count_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

`ifdef HEX_MODE_EN
    localparam digit_t DIGIT_MAX = 4'hF;
`else
    localparam digit_t DIGIT_MAX = 4'd9;
`endif

    // Advances a digit by one.
    // Wraps from DIGIT_MAX to 0 and reports the carry.
    function automatic digit_t digit_inc(input digit_t d, output logic carry);
        if (d == DIGIT_MAX) begin
            carry     = 1'b1;
            digit_inc = '0;
        end else begin
            carry     = 1'b0;
            digit_inc = d + digit_t'(1);
        end
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a counter-based debouncer.
// Ports:
//   i_Clk     system clock
//   i_Rst_L   asynchronous active-low reset
//   i_Bouncy  raw switch, asynchronous to i_Clk
//   o_Stable  debounced level, 0 after reset
module switch_debounce #(
    parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Bouncy,
    output logic o_Stable
);

    localparam int unsigned CntW = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_LIMIT - 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // The debouncer looks only at sync2_q; sync1_q may be metastable.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CntLast) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= i_Bouncy;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_Stable = stable_q;

endmodule

// File: rtl/press_count_to_nibbles.sv
// Counts debounced switch presses (on release) into a two-digit counter.
// The counter drives two nibble outputs, one per display digit.
// Ports:
//   i_Clk          system clock
//   i_Rst_L        asynchronous active-low reset
//   i_Switch       raw push-switch, 1 = pressed
//   i_Clear        synchronous clear of the count (no strobe)
//   o_Ones_Nibble  ones digit
//   o_Tens_Nibble  tens digit
//   o_Count_Pulse  one-cycle strobe in the first cycle of a new count
// HEX_MODE_EN (macro): hex digits, 00..FF, instead of BCD 00..99.
module press_count_to_nibbles
    import press_count_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Switch,
    input  logic               i_Clear,
    output logic [DIGIT_W-1:0] o_Ones_Nibble,
    output logic [DIGIT_W-1:0] o_Tens_Nibble,
    output logic               o_Count_Pulse
);

    logic   stable;
    logic   stable_prev_q;
    logic   release_evt;
    digit_t ones_q, ones_d;
    digit_t tens_q, tens_d;
    logic   pulse_q, pulse_d;
    logic   ones_carry;
    logic   tens_carry;

    switch_debounce #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_debounce (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Bouncy (i_Switch),
        .o_Stable (stable)
    );

    // A completed press is the debounced level falling.
    assign release_evt = stable_prev_q & ~stable;

    always_comb begin
        ones_d     = ones_q;
        tens_d     = tens_q;
        pulse_d    = 1'b0;
        ones_carry = 1'b0;
        tens_carry = 1'b0;
        if (i_Clear) begin
            // Clear wins over a coincident release; that press is dropped.
            ones_d = '0;
            tens_d = '0;
        end else if (release_evt) begin
            ones_d  = digit_inc(ones_q, ones_carry);
            pulse_d = 1'b1;
            if (ones_carry) begin
                tens_d = digit_inc(tens_q, tens_carry);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            stable_prev_q <= 1'b0;
            ones_q        <= '0;
            tens_q        <= '0;
            pulse_q       <= 1'b0;
        end else begin
            stable_prev_q <= stable;
            ones_q        <= ones_d;
            tens_q        <= tens_d;
            pulse_q       <= pulse_d;
        end
    end

    assign o_Ones_Nibble = ones_q;
    assign o_Tens_Nibble = tens_q;
    assign o_Count_Pulse = pulse_q;

endmodule

// File: tb/tb_press_count_to_nibbles.sv
// Directed self-checking bench for press_count_to_nibbles, DEBOUNCE_LIMIT = 4.
module tb_press_count_to_nibbles;

`ifdef HEX_MODE_EN
    localparam int BASE   = 16;
    localparam int MAXCNT = 255;
`else
    localparam int BASE   = 10;
    localparam int MAXCNT = 99;
`endif

    logic       clk;
    logic       rst_n;
    logic       sw;
    logic       clr;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       pulse;

    int n_checks = 0;
    int n_pass   = 0;

    press_count_to_nibbles #(
        .DEBOUNCE_LIMIT(4)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_n),
        .i_Switch      (sw),
        .i_Clear       (clr),
        .o_Ones_Nibble (ones),
        .o_Tens_Nibble (tens),
        .o_Count_Pulse (pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {pulse, tens, ones} for count n.
    function automatic logic [8:0] expv(input int n, input logic p);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(n / BASE);
        o = 4'(n % BASE);
        return {p, t, o};
    endfunction

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {pulse, tens, ones};
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed pulse/tens/ones=%b/%h/%h expected %b/%h/%h",
                    tag, obs[8], obs[7:4], obs[3:0], exp[8], exp[7:4], exp[3:0]);
    endtask

    // Clean press then clean release; count advances 7 cycles after release.
    task automatic press();
        sw = 1'b1;
        repeat (8) tick();
        sw = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = 1'b0;
        clr   = 1'b0;

        // 1. Reset held: outputs stay zero while the switch toggles.
        #1;
        check("reset_initial", expv(0, 1'b0));
        for (int i = 0; i < 8; i++) begin
            sw = ~sw;
            repeat (3) tick();
            check("reset_toggle", expv(0, 1'b0));
        end
        sw = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("after_reset", expv(0, 1'b0));

        // 2. Clean press/release latency: change lands exactly 7 edges after release.
        sw = 1'b1;
        repeat (10) tick();
        check("press_no_count", expv(0, 1'b0));
        sw = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("latency_wait", expv(0, 1'b0));
        end
        tick();
        check("latency_edge", expv(1, 1'b1));
        tick();
        check("pulse_one_cycle", expv(1, 1'b0));

        // 3. Bouncy release: runs of 1, 2, 3 low cycles must not qualify.
        sw = 1'b1;
        repeat (10) tick();
        sw = 1'b0; tick();
        sw = 1'b1; tick();
        sw = 1'b0; repeat (2) tick();
        sw = 1'b1; tick();
        sw = 1'b0; repeat (3) tick();
        sw = 1'b1; repeat (2) tick();
        check("bounce_no_count", expv(1, 1'b0));
        sw = 1'b0;
        repeat (12) tick();
        check("bounce_single_inc", expv(2, 1'b0));

        // 4. Run up to the maximum count, then wrap to zero.
        for (int i = 0; i < MAXCNT - 2; i++) press();
        check("at_max", expv(MAXCNT, 1'b0));
        sw = 1'b1;
        repeat (8) tick();
        sw = 1'b0;
        repeat (6) tick();
        check("pre_wrap", expv(MAXCNT, 1'b0));
        tick();
        check("wrap_pulse", expv(0, 1'b1));
        tick();
        check("wrap_after", expv(0, 1'b0));

        // 5. Clear coincident with the advance: count zero, no pulse, press lost.
        press();
        check("before_clear", expv(1, 1'b0));
        sw = 1'b1;
        repeat (8) tick();
        sw = 1'b0;
        repeat (6) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clear_beats_inc", expv(0, 1'b0));
        repeat (3) tick();
        check("clear_press_lost", expv(0, 1'b0));

        // 6. Async reset mid-debounce at count 37, held switch re-qualified.
        repeat (37) press();
        check("count_37", expv(37, 1'b0));
        sw = 1'b1;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", expv(0, 1'b0));
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("held_press_no_count", expv(0, 1'b0));
        sw = 1'b0;
        repeat (6) tick();
        check("held_release_wait", expv(0, 1'b0));
        tick();
        check("held_release_count", expv(1, 1'b1));
        tick();
        check("final", expv(1, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
